gray_counter: RTL



---
 rtl/gray_counter.sv | 87 ++++++++
 1 files changed

// File: rtl/gray_counter.sv
// Registered up/down counter presenting a binary count and its Gray code together.
// Supports binary or Gray parallel load, and wrap or saturate at the range ends.
module gray_counter #(
    parameter int unsigned             WIDTH   = 4,
    parameter bit                      WRAP    = 1'b1,
    parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic             load_is_gray_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] RstGray = RST_VAL ^ (RST_VAL >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;
    logic             w_at_max;
    logic             w_at_min;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_load_bin = load_val_i;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            w_load_bin[i] = w_load_bin[i+1] ^ load_val_i[i];
        end
    end

    assign w_at_max = (r_bin == {WIDTH{1'b1}});
    assign w_at_min = (r_bin == {WIDTH{1'b0}});

    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (load_i) begin
            w_bin_nxt = load_is_gray_i ? w_load_bin : load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (w_at_max) begin
                    w_wrap_nxt = 1'b1;
                    w_bin_nxt  = WRAP ? {WIDTH{1'b0}} : r_bin;
                end else begin
                    w_bin_nxt = r_bin + 1'b1;
                end
            end else begin
                if (w_at_min) begin
                    w_wrap_nxt = 1'b1;
                    w_bin_nxt  = WRAP ? {WIDTH{1'b1}} : r_bin;
                end else begin
                    w_bin_nxt = r_bin - 1'b1;
                end
            end
        end
    end

    // Gray is taken from the next binary value so both outputs change on the same edge.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bin  <= RST_VAL;
            r_gray <= RstGray;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin_o  = r_bin;
    assign gray_o = r_gray;
    assign wrap_o = r_wrap;

endmodule
